// File: rtl/pipe_skid_reg.sv
// Valid/ready pipeline stage with a 2-entry skid buffer, flush, bubble control and a stall counter.
// Latency is 1 cycle when empty; in_ready comes only from the state flops, so backpressure is absorbed by the skid entry.
module pipe_skid_reg #(
    parameter int                 DATA_W      = 32,
    parameter int                 CTRL_W      = 8,
    parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = '0,
    parameter int                 CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t            state, state_nxt;
    logic              load_main_in, load_main_skid, load_skid;
    logic [DATA_W-1:0] main_data, skid_data;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;

    assign out_valid = (state != EMPTY);
    assign in_ready  = (state != TWO);
    assign out_data  = main_data;
    assign out_ctrl  = main_ctrl;

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (in_valid) begin
                    state_nxt    = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (out_ready && in_valid) begin
                    load_main_in = 1'b1;
                end else if (out_ready) begin
                    state_nxt = EMPTY;
                end else if (in_valid) begin
                    state_nxt = TWO;
                    load_skid = 1'b1;
                end
            end
            TWO: begin
                if (out_ready) begin
                    state_nxt      = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        // Flush drops held entries and anything offered this cycle.
        if (flush) begin
            state_nxt      = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_data <= '0;
            main_ctrl <= CTRL_BUBBLE;
            skid_data <= '0;
            skid_ctrl <= '0;
        end else begin
            if (load_main_in) begin
                main_data <= in_data;
                main_ctrl <= in_ctrl;
            end else if (load_main_skid) begin
                main_data <= skid_data;
                main_ctrl <= skid_ctrl;
            end
            // An empty stage must never present stale control.
            if (state_nxt == EMPTY) begin
                main_ctrl <= CTRL_BUBBLE;
            end
            if (load_skid) begin
                skid_data <= in_data;
                skid_ctrl <= in_ctrl;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: vector table plus a queue scoreboard modelling FIFO order and the stall counter.
module tb_pipe_skid_reg;

    localparam logic [7:0] BUB = 8'h5A;

    logic        clk, reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data, out_data;
    logic [7:0]  in_ctrl, out_ctrl;
    logic [3:0]  stall_cnt;

    pipe_skid_reg #(.DATA_W(32), .CTRL_W(8), .CTRL_BUBBLE(BUB), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic [7:0]  c;
    } ent_t;

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic [7:0]  c;
        logic        ordy;
        logic        fl;
        logic        ev;
        logic        er;
        logic [31:0] ed;
        logic [7:0]  ec;
    } vec_t;

    ent_t q[$];
    int   m_stall;
    int   checks;
    int   errors;
    vec_t tbl[18];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic iv, input logic [31:0] d, input logic [7:0] c,
                                input logic ordy, input logic fl, input logic ev,
                                input logic er, input logic [31:0] ed, input logic [7:0] ec);
        vec_t v;
        v.iv = iv; v.d = d; v.c = c; v.ordy = ordy; v.fl = fl;
        v.ev = ev; v.er = er; v.ed = ed; v.ec = ec;
        return v;
    endfunction

    task automatic step(input logic iv, input logic [31:0] d, input logic [7:0] c,
                        input logic ordy, input logic fl, input bit use_exp,
                        input logic ev, input logic er, input logic [31:0] ed, input logic [7:0] ec);
        bit   mr;
        ent_t e;
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        mr = (q.size() < 2);
        chk("in_ready_pre", {63'd0, in_ready}, {63'd0, mr});
        @(posedge clk);
        if (q.size() > 0 && !ordy && m_stall < 15) m_stall++;
        if (fl) begin
            q.delete();
        end else begin
            if (ordy && q.size() > 0) void'(q.pop_front());
            if (iv && mr) begin
                e.d = d;
                e.c = c;
                q.push_back(e);
            end
        end
        #1;
        chk("sb_out_valid", {63'd0, out_valid}, {63'd0, (q.size() > 0)});
        if (q.size() > 0) begin
            chk("sb_out_data", {32'd0, out_data}, {32'd0, q[0].d});
            chk("sb_out_ctrl", {56'd0, out_ctrl}, {56'd0, q[0].c});
        end else begin
            chk("sb_bubble", {56'd0, out_ctrl}, {56'd0, BUB});
        end
        chk("sb_stall_cnt", {60'd0, stall_cnt}, 64'(m_stall));
        if (use_exp) begin
            chk("vec_out_valid", {63'd0, out_valid}, {63'd0, ev});
            chk("vec_in_ready", {63'd0, in_ready}, {63'd0, er});
            if (ev) chk("vec_out_data", {32'd0, out_data}, {32'd0, ed});
            chk("vec_out_ctrl", {56'd0, out_ctrl}, {56'd0, ec});
        end
    endtask

    initial begin
        checks = 0; errors = 0; m_stall = 0;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_ctrl = '0;

        // streaming
        tbl[0]  = mk(1, 32'h1,  8'h11, 1, 0, 1, 1, 32'h1,  8'h11);
        tbl[1]  = mk(1, 32'h2,  8'h12, 1, 0, 1, 1, 32'h2,  8'h12);
        tbl[2]  = mk(1, 32'h3,  8'h13, 1, 0, 1, 1, 32'h3,  8'h13);
        tbl[3]  = mk(1, 32'h4,  8'h14, 1, 0, 1, 1, 32'h4,  8'h14);
        tbl[4]  = mk(0, 32'h0,  8'h00, 1, 0, 0, 1, 32'h0,  BUB);
        // skid: A, B taken, C held off, then drained in order
        tbl[5]  = mk(1, 32'hA,  8'h1A, 0, 0, 1, 1, 32'hA,  8'h1A);
        tbl[6]  = mk(1, 32'hB,  8'h1B, 0, 0, 1, 0, 32'hA,  8'h1A);
        tbl[7]  = mk(1, 32'hC,  8'h1C, 0, 0, 1, 0, 32'hA,  8'h1A);
        tbl[8]  = mk(1, 32'hC,  8'h1C, 1, 0, 1, 1, 32'hB,  8'h1B);
        tbl[9]  = mk(1, 32'hC,  8'h1C, 1, 0, 1, 1, 32'hC,  8'h1C);
        tbl[10] = mk(0, 32'h0,  8'h00, 1, 0, 0, 1, 32'h0,  BUB);
        // flush in TWO with D offered
        tbl[11] = mk(1, 32'h11, 8'h21, 0, 0, 1, 1, 32'h11, 8'h21);
        tbl[12] = mk(1, 32'h12, 8'h22, 0, 0, 1, 0, 32'h11, 8'h21);
        tbl[13] = mk(1, 32'hD,  8'h2D, 0, 1, 0, 1, 32'h0,  BUB);
        tbl[14] = mk(0, 32'h0,  8'h00, 1, 0, 0, 1, 32'h0,  BUB);
        // bubble after drain, then flush while empty drops the offer
        tbl[15] = mk(1, 32'h55, 8'hFF, 1, 0, 1, 1, 32'h55, 8'hFF);
        tbl[16] = mk(0, 32'h0,  8'h00, 1, 0, 0, 1, 32'h0,  BUB);
        tbl[17] = mk(1, 32'h77, 8'h33, 1, 1, 0, 1, 32'h0,  BUB);

        #2;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_ctrl", {56'd0, out_ctrl}, {56'd0, BUB});
        chk("rst_out_data", {32'd0, out_data}, 64'd0);
        chk("rst_stall_cnt", {60'd0, stall_cnt}, 64'd0);
        #10 reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].iv, tbl[i].d, tbl[i].c, tbl[i].ordy, tbl[i].fl, 1'b1,
                 tbl[i].ev, tbl[i].er, tbl[i].ed, tbl[i].ec);
        end
        chk("stall_after_table", {60'd0, stall_cnt}, 64'd4);

        // asynchronous reset while holding two entries
        step(1, 32'h31, 8'h41, 0, 0, 1'b1, 1, 1, 32'h31, 8'h41);
        step(1, 32'h32, 8'h42, 0, 0, 1'b1, 1, 0, 32'h31, 8'h41);
        in_valid = 1'b0;
        #3 reset = 1'b1;
        #1;
        q.delete();
        m_stall = 0;
        chk("amid_out_valid", {63'd0, out_valid}, 64'd0);
        chk("amid_in_ready", {63'd0, in_ready}, 64'd1);
        chk("amid_out_ctrl", {56'd0, out_ctrl}, {56'd0, BUB});
        chk("amid_out_data", {32'd0, out_data}, 64'd0);
        chk("amid_stall_cnt", {60'd0, stall_cnt}, 64'd0);
        #3 reset = 1'b0;

        // stall counter saturation
        step(1, 32'h99, 8'h42, 0, 0, 1'b0, 0, 0, 32'h0, 8'h0);
        for (int i = 0; i < 20; i++) begin
            step(0, 32'h0, 8'h00, 0, 0, 1'b0, 0, 0, 32'h0, 8'h0);
        end
        chk("stall_saturated", {60'd0, stall_cnt}, 64'd15);
        chk("held_data", {32'd0, out_data}, 64'h99);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
